// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: hands memories to the engine, checks fetch beat order, counts results.
// Optional cycle counter enabled by defining MATMUL_CTRL_CYCLES_EN.
module matmul_ctrl #(
    parameter int MUL_SIZE  = 8,
    parameter int ADDR_BITS = $clog2(MUL_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_start,
    output logic                 ctrl_busy,
    output logic                 ctrl_done,
    output logic                 ctrl_err,
    output logic [31:0]          ctrl_cycles,
    input  logic                 host_req,
    output logic                 host_gnt,
    output logic                 mem_sel,
    output logic                 fetch_start,
    input  logic                 fetch_valid,
    input  logic [ADDR_BITS-1:0] fetch_row_no,
    input  logic [ADDR_BITS-1:0] fetch_col_no,
    input  logic                 res_valid
);

    localparam int CW = 2 * ADDR_BITS + 1;
    localparam logic [CW-1:0] NN   = CW'(MUL_SIZE * MUL_SIZE);
    localparam logic [CW-1:0] LAST = NN - CW'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] res_cnt;
    logic          beat_ok;
    logic          res_take;
    logic          err_set;
    logic          sel_next;
    logic          accept;

    always_comb begin
        // With N a power of two the beat count splits directly into (row, col).
        beat_ok  = (fetch_row_no == beat_cnt[2*ADDR_BITS-1:ADDR_BITS])
                && (fetch_col_no == beat_cnt[ADDR_BITS-1:0]);
        res_take = res_valid && (res_cnt != NN)
                && (state == RUN || state == DRAIN);
        accept   = (state == IDLE) && ctrl_start;
        err_set  = (fetch_valid && (state != RUN || !beat_ok))
                || (res_valid && (state == IDLE || state == DONE))
                || (res_valid && (state == RUN || state == DRAIN)
                    && (res_cnt == NN));
        state_next = state;
        unique case (state)
            IDLE:    if (ctrl_start) state_next = START;
            START:   state_next = RUN;
            RUN:     if (fetch_valid && beat_cnt == LAST) state_next = DRAIN;
            DRAIN:   if (res_cnt == NN || (res_take && res_cnt == LAST))
                         state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        sel_next = (state_next == START) || (state_next == RUN)
                || (state_next == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ctrl_busy   <= 1'b0;
            ctrl_done   <= 1'b0;
            ctrl_err    <= 1'b0;
            mem_sel     <= 1'b0;
            fetch_start <= 1'b0;
            host_gnt    <= 1'b0;
            beat_cnt    <= '0;
            res_cnt     <= '0;
        end else begin
            state       <= state_next;
            ctrl_busy   <= (state_next != IDLE);
            mem_sel     <= sel_next;
            fetch_start <= (state_next == START);
            host_gnt    <= host_req & ~sel_next;
            if (accept) begin
                beat_cnt  <= '0;
                res_cnt   <= '0;
                ctrl_done <= 1'b0;
                ctrl_err  <= err_set;
            end else begin
                if (state == RUN && fetch_valid)
                    beat_cnt <= beat_cnt + CW'(1);
                if (res_take)
                    res_cnt <= res_cnt + CW'(1);
                if (err_set)
                    ctrl_err <= 1'b1;
                if (state == DONE)
                    ctrl_done <= 1'b1;
            end
        end
    end

`ifdef MATMUL_CTRL_CYCLES_EN
    logic [31:0] cycles;

    // The accepting IDLE cycle counts as the first cycle of the operation.
    always_ff @(posedge clk) begin
        if (!rst)
            cycles <= '0;
        else if (accept)
            cycles <= 32'd1;
        else if (state != IDLE && cycles != '1)
            cycles <= cycles + 32'd1;
    end

    assign ctrl_cycles = cycles;
`else
    assign ctrl_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl (N=4) with randomized beat gaps and a
// schedule-level reference model of the expected handshake timeline.
module tb_matmul_ctrl;

    localparam int N  = 4;
    localparam int AB = 2;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_start;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          ctrl_err;
    logic [31:0]   ctrl_cycles;
    logic          host_req;
    logic          host_gnt;
    logic          mem_sel;
    logic          fetch_start;
    logic          fetch_valid;
    logic [AB-1:0] fetch_row_no;
    logic [AB-1:0] fetch_col_no;
    logic          res_valid;

    int total = 0;
    int bad   = 0;

    int            beat_cyc [NN];
    logic [AB-1:0] brow     [NN];
    logic [AB-1:0] bcol     [NN];

    always #5 clk = ~clk;

    matmul_ctrl #(.MUL_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_start   (ctrl_start),
        .ctrl_busy    (ctrl_busy),
        .ctrl_done    (ctrl_done),
        .ctrl_err     (ctrl_err),
        .ctrl_cycles  (ctrl_cycles),
        .host_req     (host_req),
        .host_gnt     (host_gnt),
        .mem_sel      (mem_sel),
        .fetch_start  (fetch_start),
        .fetch_valid  (fetch_valid),
        .fetch_row_no (fetch_row_no),
        .fetch_col_no (fetch_col_no),
        .res_valid    (res_valid)
    );

    task automatic drive_idle();
        ctrl_start   = 1'b0;
        fetch_valid  = 1'b0;
        res_valid    = 1'b0;
        fetch_row_no = '0;
        fetch_col_no = '0;
    endtask

    // Expected cycle count: accepting cycle through the DONE cycle.
    function automatic logic [31:0] exp_cycles(input int u);
`ifdef MATMUL_CTRL_CYCLES_EN
        return 32'(u + 2);
`else
        return 32'(u - u);
`endif
    endfunction

    // One full operation; cycle 0 is the start-sampling cycle, u the last result cycle.
    task automatic run_op(input string name, input int gap_max, input int bad_idx,
                          input logic busy_pulse, input logic extra_res);
        int u;
        int k;
        int first;
        logic exp_err;
        first = (gap_max == 0) ? 3 : int'($urandom_range(2, 4));
        for (int i = 0; i < NN; i++) begin
            beat_cyc[i] = (i == 0) ? first
                        : beat_cyc[i-1] + 1 + int'($urandom_range(0, gap_max));
            brow[i] = AB'(i / N);
            bcol[i] = AB'(i % N);
            if (i == bad_idx) bcol[i] = AB'((i % N) + 1);
        end
        u = beat_cyc[NN-1] + 3;
        exp_err = (bad_idx >= 0) || extra_res;
        host_req = 1'b1;
        for (int c = 0; c <= u + 1; c++) begin
            drive_idle();
            ctrl_start = (c == 0)
                      || (busy_pulse && (c == first + 2 || c == u + 1));
            for (int i = 0; i < NN; i++) begin
                if (beat_cyc[i] == c) begin
                    fetch_valid  = 1'b1;
                    fetch_row_no = brow[i];
                    fetch_col_no = bcol[i];
                end
                if (beat_cyc[i] + 3 == c) res_valid = 1'b1;
            end
            if (extra_res && c == u + 1) res_valid = 1'b1;
            @(negedge clk);
            k = c + 1;
            total++;
            if (fetch_start !== (k == 1)) begin
                bad++;
                $display("FAIL %s fetch_start k=%0d got=%b exp=%b", name, k, fetch_start, k == 1);
            end
            total++;
            if (mem_sel !== (k <= u)) begin
                bad++;
                $display("FAIL %s mem_sel k=%0d got=%b exp=%b", name, k, mem_sel, k <= u);
            end
            total++;
            if (ctrl_busy !== (k <= u + 1)) begin
                bad++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, ctrl_busy, k <= u + 1);
            end
            total++;
            if (host_gnt !== (k > u)) begin
                bad++;
                $display("FAIL %s host_gnt k=%0d got=%b exp=%b", name, k, host_gnt, k > u);
            end
            total++;
            if (ctrl_done !== (k >= u + 2)) begin
                bad++;
                $display("FAIL %s done k=%0d got=%b exp=%b", name, k, ctrl_done, k >= u + 2);
            end
        end
        drive_idle();
        total++;
        if (ctrl_err !== exp_err) begin
            bad++;
            $display("FAIL %s err got=%b exp=%b", name, ctrl_err, exp_err);
        end
        total++;
        if (ctrl_cycles !== exp_cycles(u)) begin
            bad++;
            $display("FAIL %s cycles got=%0d exp=%0d", name, ctrl_cycles, exp_cycles(u));
        end
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if ({ctrl_busy, ctrl_done, ctrl_err, mem_sel, fetch_start, host_gnt} !== 6'b0
            || ctrl_cycles !== 32'd0) begin
            bad++;
            $display("FAIL %s outs got=%b%b%b%b%b%b cyc=%0d exp=000000 cyc=0", name,
                     ctrl_busy, ctrl_done, ctrl_err, mem_sel, fetch_start, host_gnt,
                     ctrl_cycles);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        host_req = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        run_op("nominal", 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_order_error();
        run_op("order_err", 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start();
        run_op("busy_start", 1, -1, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (fetch_start !== 1'b0 || ctrl_done !== 1'b1) begin
            bad++;
            $display("FAIL busy_start after fs=%b done=%b exp fs=0 done=1", fetch_start, ctrl_done);
        end
    endtask

    task automatic test_extra_result();
        run_op("extra_done", 0, -1, 1'b0, 1'b1);
        run_op("clean_after", 0, -1, 1'b0, 1'b0);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        total++;
        if (ctrl_err !== 1'b1 || ctrl_done !== 1'b1) begin
            bad++;
            $display("FAIL extra_idle err=%b done=%b exp err=1 done=1", ctrl_err, ctrl_done);
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        host_req = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            drive_idle();
            ctrl_start = (c == 0);
            if (c >= 3 && c < 10) begin
                fetch_valid  = 1'b1;
                fetch_row_no = AB'((c - 3) / N);
                fetch_col_no = AB'((c - 3) % N);
            end
            if (c == 10) rst = 1'b0;
            @(negedge clk);
        end
        check_reset_vals("reset_mid");
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        run_op("after_reset", 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            run_op("random", 3,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NN - 1)) : -1,
                   1'b0, 1'b0);
        end
    endtask

    initial begin
        drive_idle();
        host_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_order_error();
        test_busy_start();
        test_extra_result();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
